// File: rtl/sp_rd_lvds_rx.sv
// SuperMario readout receive front-end: synchronises lane/strobe inputs, corrects
// pair polarity, packs samples into 32-bit words and buffers them in an FWFT FIFO.
module sp_rd_lvds_rx #(
  parameter int                N_LANE      = 8,
  parameter logic [N_LANE-1:0] POL_MASK    = {N_LANE{1'b1}},
  parameter int                SYNC_STAGES = 2,
  parameter int                FIFO_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            inv_en,
  input  logic [N_LANE-1:0]               lane_in,
  input  logic                            update_in,
  input  logic                            eof_in,
  output logic [31:0]                     dout,
  output logic                            dout_last,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     frame_cnt,
  output logic                            overflow
);

  localparam int SPW   = 32 / N_LANE;
  localparam int CNT_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPW - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [N_LANE-1:0]      lane_sync_r [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] upd_sync_r;
  logic [SYNC_STAGES-1:0] eof_sync_r;
  logic                   upd_prev_r;
  logic                   eof_prev_r;
  logic                   upd_edge_s;
  logic                   eof_edge_s;

  logic [N_LANE-1:0]      sample_s;
  logic [31:0]            pack_r;
  logic [31:0]            packed_s;
  logic [31:0]            pack_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   push_s;
  logic                   push_last_s;
  logic [31:0]            push_word_s;
  logic [15:0]            frame_cnt_r;

  logic [32:0]            mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [LVL_W-1:0]       level_r;
  logic [LVL_W-1:0]       level_nxt_s;
  logic                   dout_valid_r;
  logic                   overflow_r;
  logic                   pop_s;
  logic                   accept_s;

  // Input synchronisers plus one edge-detect flop per strobe; these run regardless of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) lane_sync_r[i] <= '0;
      upd_sync_r <= '0;
      eof_sync_r <= '0;
      upd_prev_r <= 1'b0;
      eof_prev_r <= 1'b0;
    end else begin
      lane_sync_r[0] <= lane_in;
      for (int i = 1; i < SYNC_STAGES; i++) lane_sync_r[i] <= lane_sync_r[i-1];
      upd_sync_r <= {upd_sync_r[SYNC_STAGES-2:0], update_in};
      eof_sync_r <= {eof_sync_r[SYNC_STAGES-2:0], eof_in};
      upd_prev_r <= upd_sync_r[SYNC_STAGES-1];
      eof_prev_r <= eof_sync_r[SYNC_STAGES-1];
    end
  end

  assign upd_edge_s = upd_sync_r[SYNC_STAGES-1] & ~upd_prev_r;
  assign eof_edge_s = eof_sync_r[SYNC_STAGES-1] & ~eof_prev_r;

  // Packing: a same-cycle sample is merged before the EOF rule closes the word.
  always_comb begin
    sample_s    = lane_sync_r[SYNC_STAGES-1] ^ (POL_MASK & {N_LANE{inv_en}});
    packed_s    = pack_r;
    packed_s[cnt_r*N_LANE +: N_LANE] = sample_s;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    push_word_s = packed_s;
    pack_nxt_s  = pack_r;
    cnt_nxt_s   = cnt_r;
    if (!enable) begin
      pack_nxt_s = 32'h0;
      cnt_nxt_s  = '0;
    end else if (eof_edge_s) begin
      push_s      = 1'b1;
      push_last_s = 1'b1;
      push_word_s = upd_edge_s ? packed_s : pack_r;
      pack_nxt_s  = 32'h0;
      cnt_nxt_s   = '0;
    end else if (upd_edge_s) begin
      if (cnt_r == CNT_LAST) begin
        push_s     = 1'b1;
        pack_nxt_s = 32'h0;
        cnt_nxt_s  = '0;
      end else begin
        pack_nxt_s = packed_s;
        cnt_nxt_s  = cnt_r + 1'b1;
      end
    end else begin
      pack_nxt_s = pack_r;
      cnt_nxt_s  = cnt_r;
    end
  end

  // Pack register, sample counter and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_r      <= 32'h0;
      cnt_r       <= '0;
      frame_cnt_r <= 16'h0;
    end else begin
      pack_r <= pack_nxt_s;
      cnt_r  <= cnt_nxt_s;
      if (enable && eof_edge_s) frame_cnt_r <= frame_cnt_r + 16'h1;
    end
  end

  // A full FIFO still accepts when the head is popped in the same cycle.
  always_comb begin
    pop_s    = dout_valid_r & dout_ready;
    accept_s = push_s & ((level_r != LVL_FULL) | pop_s);
    case ({accept_s, pop_s})
      2'b10:   level_nxt_s = level_r + 1'b1;
      2'b01:   level_nxt_s = level_r - 1'b1;
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage; contents need no reset because the head is masked by dout_valid.
  always_ff @(posedge clk) begin
    if (accept_s) mem_r[wr_ptr_r] <= {push_last_s, push_word_s};
  end

  // FIFO pointers, occupancy, valid flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      dout_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      level_r      <= level_nxt_s;
      dout_valid_r <= (level_nxt_s != '0);
      if (push_s && !accept_s) overflow_r <= 1'b1;
    end
  end

  assign dout       = dout_valid_r ? mem_r[rd_ptr_r][31:0] : 32'h0;
  assign dout_last  = dout_valid_r & mem_r[rd_ptr_r][32];
  assign dout_valid = dout_valid_r;
  assign fifo_level = level_r;
  assign frame_cnt  = frame_cnt_r;
  assign overflow   = overflow_r;

endmodule

// File: doc/sp_rd_lvds_rx.md
# sp_rd_lvds_rx

Parametrised receive front-end for the SuperMario readout path, sitting behind the differential input buffers and in front of the packet/transfer logic. It synchronises N_LANE single-ended lane bits plus the UPDATE and EOF strobes into `clk`, applies per-lane polarity correction for board-level pair swaps, and packs successive samples into 32-bit words. Completed words go into a first-word-fall-through FIFO with a valid/ready output. It also tracks frame boundaries and reports FIFO overflow.

## Interface
- N_LANE, 8, data lanes per sample; must divide 32 (1, 2, 4, 8, 16, 32)
- POL_MASK, {N_LANE{1'b1}}, per-lane inversion mask; bit i = 1 means lane i is flipped on the board
- SYNC_STAGES, 2, synchroniser depth for lanes/update/eof, ≥2
- FIFO_DEPTH, 16, output FIFO depth in words, power of two, ≥4
- Timing: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  capture enable
- inv_en  in  1  1 = apply POL_MASK; 0 = pass lanes unmodified
- lane_in  in  N_LANE  raw lane bits (post-IBUFDS, asynchronous)
- update_in  in  1  sample strobe (asynchronous; data valid on its rising edge)
- eof_in  in  1  end-of-frame strobe (asynchronous)
- dout  out  32  FIFO head word; 0 when dout_valid = 0
- dout_last  out  1  head word closes a frame
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accept
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held
- frame_cnt  out  16  EOF count, wraps 0xFFFF→0x0000
- overflow  out  1  sticky; a word was dropped

## Operation
- SPW = 32/N_LANE samples per word.
- lane_in, update_in and eof_in each pass through a SYNC_STAGES flop chain, followed by one extra flop used for edge detection.
- upd_edge = sync_update & ~prev_update; eof_edge is formed the same way.
- Sample = sync_lane ^ (inv_en ? POL_MASK : 0).
- On upd_edge with enable = 1: sample k of a word (k = sample_cnt) goes to bits [k*N_LANE +: N_LANE], LSB first.
  - If k = SPW-1, push the word with last = 0 and clear sample_cnt.
  - Otherwise, increment sample_cnt.
- On eof_edge with enable = 1: increment frame_cnt.
  - If sample_cnt > 0, push the partial word with unused upper bits zero and last = 1, then clear the pack register and sample_cnt.
  - If sample_cnt = 0, push a marker word 32'h0 with last = 1.
- Simultaneous upd_edge and eof_edge: the sample is packed first, then the EOF rule applies to the result. Exactly one push occurs, with last = 1. If the sample completes the word, that full word carries last = 1.
- enable = 0:
  - Edges are ignored and frame_cnt holds.
  - sample_cnt and the pack register clear; any partial word is discarded.
  - The synchronisers and edge flops keep running, so raising enable while update_in is high does not produce a false edge.
  - The FIFO continues to drain.
- FIFO:
  - pop = dout_valid & dout_ready.
  - A push is accepted if level < FIFO_DEPTH, or if level = FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the pushed word is dropped and overflow is set to 1; only rst clears overflow.
  - Order is preserved, and dout_last travels with its word.
- rst, including mid-frame:
  - Outputs: dout, dout_last, dout_valid, fifo_level, frame_cnt and overflow all go to 0.
  - Internal state: FIFO pointers, sample_cnt, pack register, synchronisers and edge flops are cleared.

## Timing
- Latency:
  - Let E0 be the clk edge that first samples the completing update_in high.
  - upd_edge is high in the cycle after edge E0+SYNC_STAGES-1.
  - The FIFO write happens at edge E0+SYNC_STAGES.
  - dout_valid is high from edge E0+SYNC_STAGES onward (2 edges for the default).
  - eof_edge has the same latency.
- Output path: dout and dout_last are combinational from the FIFO head; dout_valid and fifo_level are registered.
- Pop: a pop at edge E presents the next word, or drops dout_valid, after E. Push and pop in the same cycle leave fifo_level unchanged.
- Strobe width: update_in and eof_in must stay high ≥ 1 clk and low ≥ 1 clk between edges. lane_in must be stable from SYNC_STAGES cycles before the rising edge of update_in until 1 cycle after it.
- Throughput: one push per cycle maximum; sustained rate is bounded by the update rate.

## Test plan
- Reset: assert rst for 3 cycles during activity → all outputs 0, and the next frame starts at sample 0 with frame_cnt = 0.
- Polarity and packing (N_LANE = 8, POL_MASK = 8'hFF, inv_en = 1):
  - Stimulus: lane_in = 8'hEE, 8'hDD, 8'hCC, 8'hBB on 4 update pulses.
  - Expected: one word 32'h44332211 with dout_last = 0, and dout_valid rising exactly 2 edges after the 4th update is first sampled high.
- Partial frame (inv_en = 0): samples 8'hAA, 8'hBB, then eof_in → word 32'h0000BBAA with dout_last = 1, frame_cnt = 1.
- EOF corner cases:
  - eof_in with sample_cnt = 0 → marker word 32'h0, dout_last = 1.
  - eof_in rising in the same cycle as the 4th update → exactly one word with last = 1; fifo_level increments by 1.
- Overflow (FIFO_DEPTH = 16): with dout_ready = 0, push 17 words → fifo_level = 16 and overflow = 1. Draining returns words 1–16 in order, and overflow stays 1.
- Enable drop: clear enable after 2 samples, re-enable, send 4 samples → only the 4 new samples appear; no false edge even if update_in is high at re-enable.
